// File: rtl/hilo_muldiv_unit_if.sv
// Decoder-side bundle for the HI/LO multiply/divide unit: write requests, sources, operands, results.
// The decoder drives the requests and operands; the unit drives hi/lo/busy/stall.
// stall is combinational in the unit, so the decoder sees it in the same cycle it presents a request.
interface hilo_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             hi_w;
  logic             lo_w;
  logic [1:0]       hi_src;
  logic [1:0]       lo_src;
  logic             unsigned_instr;
  logic             hilo_rd;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             stall;

  modport master (
    output hi_w, lo_w, hi_src, lo_src, unsigned_instr, hilo_rd, rs_data, rt_data,
    input  hi, lo, busy, stall
  );

  modport slave (
    input  hi_w, lo_w, hi_src, lo_src, unsigned_instr, hilo_rd, rs_data, rt_data,
    output hi, lo, busy, stall
  );
endinterface

// File: rtl/hilo_muldiv_unit.sv
// HI/LO register file with single-cycle MULT/MULTU, MTHI/MTLO and a 33-cycle restoring DIV/DIVU.
// Latency: MUL/MTxx visible one cycle after issue; DIV result visible one cycle after E33 (E0 = accept).
// Backpressure: while a divide is in flight any HI/LO access raises stall and is ignored until busy falls.
module hilo_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input logic              clk,
  input logic              rst_n,
  hilo_muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, DIV, FIX} state_t;

  localparam logic [1:0] SRC_RS  = 2'b00;
  localparam logic [1:0] SRC_MUL = 2'b01;
  localparam logic [1:0] SRC_DIV = 2'b10;

  state_t           state_q, state_d;
  logic             busy_q, busy_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] rem_q, rem_d;     // partial remainder (magnitude)
  logic [WIDTH-1:0] quo_q, quo_d;     // dividend shifts out, quotient shifts in
  logic [WIDTH-1:0] dvsr_q, dvsr_d;   // divisor magnitude
  logic [WIDTH-1:0] raw_rs_q, raw_rs_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic             dvz_q, dvz_d;

  logic             stall;
  logic             is_mul, is_div, is_mthi, is_mtlo;
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [2*WIDTH-1:0] mul_a, mul_b, prod;
  logic [WIDTH:0]   rem_sh;           // WIDTH+1 bit shifted partial remainder
  logic             fits;

  assign stall     = busy_q & (bus.hi_w | bus.lo_w | bus.hilo_rd);
  assign bus.stall = stall;
  assign bus.busy  = busy_q;
  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;

  assign is_mul  = bus.hi_w & bus.lo_w & (bus.hi_src == SRC_MUL) & (bus.lo_src == SRC_MUL);
  assign is_div  = bus.hi_w & bus.lo_w & (bus.hi_src == SRC_DIV) & (bus.lo_src == SRC_DIV);
  assign is_mthi = bus.hi_w & (bus.hi_src == SRC_RS);
  assign is_mtlo = bus.lo_w & (bus.lo_src == SRC_RS);

  // Magnitudes; negating 0x80000000 yields 0x80000000, read as unsigned.
  assign rs_neg = ~bus.unsigned_instr & bus.rs_data[WIDTH-1];
  assign rt_neg = ~bus.unsigned_instr & bus.rt_data[WIDTH-1];
  assign rs_mag = rs_neg ? (~bus.rs_data + 1'b1) : bus.rs_data;
  assign rt_mag = rt_neg ? (~bus.rt_data + 1'b1) : bus.rt_data;

  // Sign- or zero-extend to 2*WIDTH; the low 2*WIDTH bits of the product are exact either way.
  assign mul_a = {{WIDTH{rs_neg}}, bus.rs_data};
  assign mul_b = {{WIDTH{rt_neg}}, bus.rt_data};
  assign prod  = mul_a * mul_b;

  // One restoring step: bring in the next dividend bit and subtract if the divisor fits.
  assign rem_sh = {rem_q, quo_q[WIDTH-1]};
  assign fits   = (rem_sh >= {1'b0, dvsr_q});

  // Next-state: command decode in IDLE, iteration in DIV, sign fix and HI/LO write in FIX.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvsr_d    = dvsr_q;
    raw_rs_d  = raw_rs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    dvz_d     = dvz_q;
    case (state_q)
      IDLE: begin
        if (!stall) begin
          if (is_mul) begin
            hi_d = prod[2*WIDTH-1:WIDTH];
            lo_d = prod[WIDTH-1:0];
          end
          if (is_mthi) hi_d = bus.rs_data;
          if (is_mtlo) lo_d = bus.rs_data;
          if (is_div) begin
            state_d   = DIV;
            busy_d    = 1'b1;
            cnt_d     = '0;
            rem_d     = '0;
            quo_d     = rs_mag;
            dvsr_d    = rt_mag;
            raw_rs_d  = bus.rs_data;
            neg_quo_d = rs_neg ^ rt_neg;
            neg_rem_d = rs_neg;
            dvz_d     = (bus.rt_data == '0);
          end
        end
      end
      DIV: begin
        rem_d = fits ? WIDTH'(rem_sh - {1'b0, dvsr_q}) : rem_sh[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], fits};
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = FIX;
      end
      FIX: begin
        if (dvz_q) begin
          lo_d = '1;
          hi_d = raw_rs_q;
        end else begin
          lo_d = neg_quo_q ? (~quo_q + 1'b1) : quo_q;
          hi_d = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
        end
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State register; reset discards any in-flight divide and clears HI/LO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvsr_q    <= '0;
      raw_rs_q  <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      dvz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvsr_q    <= dvsr_d;
      raw_rs_q  <= raw_rs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      dvz_q     <= dvz_d;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed bench for hilo_muldiv_unit: moves, multiplies, divides, stall hazard, corners, reset mid-divide.
// Expected HI/LO pairs are queued when a MUL/DIV is issued and compared when the result is due.
// Inputs change 1ns after the rising edge; outputs are sampled at that same point.
module tb_hilo_muldiv_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model_hi;
  logic [31:0] model_lo;

  hilo_muldiv_unit_if #(.WIDTH(32)) bus ();

  hilo_muldiv_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cmd();
    bus.hi_w           = 1'b0;
    bus.lo_w           = 1'b0;
    bus.hi_src         = 2'b00;
    bus.lo_src         = 2'b00;
    bus.unsigned_instr = 1'b0;
    bus.hilo_rd        = 1'b0;
    bus.rs_data        = '0;
    bus.rt_data        = '0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_check(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, "_hi"}, bus.hi, e.hi);
      chk({tag, "_lo"}, bus.lo, e.lo);
      model_hi = e.hi;
      model_lo = e.lo;
    end
  endtask

  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic u, input logic [31:0] ehi, input logic [31:0] elo);
    exp_t e;
    bus.hi_w = 1'b1; bus.lo_w = 1'b1; bus.hi_src = 2'b01; bus.lo_src = 2'b01;
    bus.unsigned_instr = u; bus.rs_data = a; bus.rt_data = b;
    e.hi = ehi; e.lo = elo; sb.push_back(e);
    tick();
    idle_cmd();
    pop_check(tag);
  endtask

  task automatic issue_div(input logic [31:0] a, input logic [31:0] b, input logic u);
    bus.hi_w = 1'b1; bus.lo_w = 1'b1; bus.hi_src = 2'b10; bus.lo_src = 2'b10;
    bus.unsigned_instr = u; bus.rs_data = a; bus.rt_data = b;
    tick();
    idle_cmd();
  endtask

  // poke > 0: present an MTHI on that busy cycle, which must stall and be dropped.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic u, input logic [31:0] ehi, input logic [31:0] elo,
                        input int poke);
    exp_t e;
    int   n;
    e.hi = ehi; e.lo = elo; sb.push_back(e);
    issue_div(a, b, u);
    chk({tag, "_busy_e0"}, {31'd0, bus.busy}, 32'd1);
    chk({tag, "_hold_hi"}, bus.hi, model_hi);
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      if (poke > 0 && n == poke) begin
        bus.hi_w = 1'b1; bus.hi_src = 2'b00; bus.rs_data = 32'hDEADBEEF;
        #1;
        chk({tag, "_poke_stall"}, {31'd0, bus.stall}, 32'd1);
      end else if (poke > 0 && n == poke + 1) begin
        idle_cmd();
        chk({tag, "_poke_hold_hi"}, bus.hi, model_hi);
      end
      tick();
    end
    chk({tag, "_busy_cycles"}, n, 32'd33);
    pop_check(tag);
  endtask

  initial begin
    int n;
    checks   = 0;
    errors   = 0;
    model_hi = '0;
    model_lo = '0;
    idle_cmd();
    rst_n = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_hi", bus.hi, 32'h0);
    chk("rst_lo", bus.lo, 32'h0);
    chk("rst_busy", {31'd0, bus.busy}, 32'd0);
    rst_n = 1'b1;
    tick();

    // Moves
    bus.hi_w = 1'b1; bus.hi_src = 2'b00; bus.rs_data = 32'h12345678;
    tick();
    idle_cmd();
    chk("mthi_hi", bus.hi, 32'h12345678);
    chk("mthi_lo", bus.lo, 32'h0);
    bus.lo_w = 1'b1; bus.lo_src = 2'b00; bus.rs_data = 32'h9ABCDEF0;
    tick();
    idle_cmd();
    chk("mtlo_lo", bus.lo, 32'h9ABCDEF0);
    chk("mtlo_hi", bus.hi, 32'h12345678);

    // Reserved source writes nothing
    bus.hi_w = 1'b1; bus.lo_w = 1'b1; bus.hi_src = 2'b11; bus.lo_src = 2'b11; bus.rs_data = 32'h55555555;
    tick();
    idle_cmd();
    chk("rsvd_hi", bus.hi, 32'h12345678);
    chk("rsvd_lo", bus.lo, 32'h9ABCDEF0);

    // Multiplies
    do_mul("mult",  32'hFFFFFFFF, 32'h00000002, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFE);
    do_mul("multu", 32'hFFFFFFFF, 32'h00000002, 1'b1, 32'h00000001, 32'hFFFFFFFE);
    do_mul("mult_neg", 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000);

    // Divides
    do_div("div_m7_2",   32'hFFFFFFF9, 32'h2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 0);
    do_div("divu_f9_2",  32'hFFFFFFF9, 32'h2, 1'b1, 32'h00000001, 32'h7FFFFFFC, 0);
    do_div("div_5_0",    32'h5,        32'h0, 1'b0, 32'h00000005, 32'hFFFFFFFF, 10);
    do_div("div_min_m1", 32'h80000000, 32'hFFFFFFFF, 1'b0, 32'h0, 32'h80000000, 0);
    do_div("div_7_m2",   32'h7,        32'hFFFFFFFE, 1'b0, 32'h1, 32'hFFFFFFFD, 0);

    // Hazard: DIV 100/7 then MFHI held until it gets through
    begin
      exp_t e;
      e.hi = 32'd2; e.lo = 32'd14; sb.push_back(e);
    end
    issue_div(32'd100, 32'd7, 1'b0);
    bus.hilo_rd = 1'b1;
    #1;
    n = 0;
    while (bus.stall && n < 100) begin
      n++;
      tick();
    end
    chk("haz_stall_cycles", n, 32'd33);
    chk("haz_stall_low", {31'd0, bus.stall}, 32'd0);
    idle_cmd();
    pop_check("haz");

    // Non-HI/LO instruction during a divide does not stall
    issue_div(32'd100, 32'd7, 1'b0);
    bus.rs_data = 32'h11111111; bus.rt_data = 32'h22222222;
    #1;
    chk("add_no_stall", {31'd0, bus.stall}, 32'd0);
    chk("add_busy", {31'd0, bus.busy}, 32'd1);
    idle_cmd();
    n = 0;
    while (bus.busy && n < 100) begin
      n++;
      tick();
    end
    chk("add_div_hi", bus.hi, 32'd2);

    // Reset mid-divide
    issue_div(32'd100, 32'd7, 1'b0);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", {31'd0, bus.busy}, 32'd0);
    chk("mid_rst_hi", bus.hi, 32'h0);
    chk("mid_rst_lo", bus.lo, 32'h0);
    tick();
    rst_n = 1'b1;
    model_hi = '0;
    model_lo = '0;
    tick();
    do_div("post_rst", 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
